// File: rtl/matrix_rd.sv
// Operand fetch engine: reads four consecutive RAM words and presents their 18-bit payloads as OP1..OP4.
// Optional upper-bits check of each captured word is enabled by defining MATRIX_RD_ZCHK_EN.
module matrix_rd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        addr_ld,
  input  logic [5:0]  addr_in,
  input  logic [31:0] dataRAM,
  output logic        re_n,
  output logic [7:0]  r_addr,
  output logic [17:0] OP1,
  output logic [17:0] OP2,
  output logic [17:0] OP3,
  output logic [17:0] OP4,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LAST  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  beat_q;
  logic [5:0]  ptr_q;
  logic [17:0] buf0_q, buf1_q, buf2_q;
  logic [17:0] op1_q, op2_q, op3_q, op4_q;
  logic        re_n_q;
  logic        valid_q;
  logic        busy_q;
  logic        cap_read;
  logic        cap_any;

  // Words 0..2 arrive during the last three READ cycles; word 3 arrives in LAST.
  assign cap_read = (state_q == READ) && (beat_q != 2'd0);
  assign cap_any  = cap_read || (state_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ptr_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      buf2_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      op4_q   <= '0;
      re_n_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Three-deep shift buffer: after three captures buf0..buf2 hold words 0..2.
      if (cap_read) begin
        buf0_q <= buf1_q;
        buf1_q <= buf2_q;
        buf2_q <= dataRAM[17:0];
      end
      case (state_q)
        IDLE: begin
          if (addr_ld) ptr_q <= addr_in;
          if (start) begin
            state_q <= READ;
            beat_q  <= '0;
            re_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          ptr_q  <= ptr_q + 6'd1;
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_q <= LAST;
            re_n_q  <= 1'b1;
          end
        end
        LAST: begin
          // Word 3 goes straight to OP4 so all operands turn over together entering VALID.
          op1_q   <= buf0_q;
          op2_q   <= buf1_q;
          op3_q   <= buf2_q;
          op4_q   <= dataRAM[17:0];
          valid_q <= 1'b1;
          state_q <= VALID;
        end
        VALID: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MATRIX_RD_ZCHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (cap_any && (dataRAM[31:18] != 14'd0)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_upper;

  assign unused_upper = cap_any ^ (^dataRAM[31:18]);
  assign err          = 1'b0;
`endif

  assign re_n   = re_n_q;
  assign r_addr = {2'b00, ptr_q};
  assign OP1    = op1_q;
  assign OP2    = op2_q;
  assign OP3    = op3_q;
  assign OP4    = op4_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_matrix_rd.sv
// Directed bench for matrix_rd: bursts, back-to-back, ignored mid-burst requests, wrap, reset abort, upper-bit check.
module tb_matrix_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        addr_ld;
  logic [5:0]  addr_in;
  logic [31:0] dataRAM;
  logic        re_n;
  logic [7:0]  r_addr;
  logic [17:0] OP1, OP2, OP3, OP4;
  logic        valid;
  logic        busy;
  logic        err;

  logic [31:0] mem [64];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        zchk;

  matrix_rd dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr_ld (addr_ld),
    .addr_in (addr_in),
    .dataRAM (dataRAM),
    .re_n    (re_n),
    .r_addr  (r_addr),
    .OP1     (OP1),
    .OP2     (OP2),
    .OP3     (OP3),
    .OP4     (OP4),
    .valid   (valid),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address issued in cycle k appears in cycle k+1.
  always @(posedge clk) begin
    if (!re_n) dataRAM <= mem[r_addr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 (IDLE); returns in cycle 7 (IDLE again).
  task automatic burst(input logic ld, input logic [5:0] a_in, input logic [5:0] a,
                       input logic [17:0] e1, input logic [17:0] e2,
                       input logic [17:0] e3, input logic [17:0] e4,
                       input logic [17:0] prev4, input logic err3, input logic err6,
                       input logic inject);
    logic [5:0] ea;
    addr_ld = ld;
    addr_in = a_in;
    start   = 1'b1;
    step();
    start   = 1'b0;
    addr_ld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ea = a + 6'(i - 1);
      check("re_n_rd", 32'(re_n), 32'd0);
      check("r_addr_rd", 32'(r_addr), 32'(ea));
      check("busy_rd", 32'(busy), 32'd1);
      check("valid_rd", 32'(valid), 32'd0);
      if (i == 3) begin
        check("err_c3", 32'(err), 32'(err3));
        if (inject) begin
          start   = 1'b1;
          addr_ld = 1'b1;
          addr_in = 6'd20;
        end
      end
      step();
      start   = 1'b0;
      addr_ld = 1'b0;
    end
    check("re_n_last", 32'(re_n), 32'd1);
    check("busy_last", 32'(busy), 32'd1);
    check("valid_last", 32'(valid), 32'd0);
    check("op4_hold", 32'(OP4), 32'(prev4));
    step();
    check("valid_v", 32'(valid), 32'd1);
    check("busy_v", 32'(busy), 32'd1);
    check("op1", 32'(OP1), 32'(e1));
    check("op2", 32'(OP2), 32'(e2));
    check("op3", 32'(OP3), 32'(e3));
    check("op4", 32'(OP4), 32'(e4));
    check("err_c6", 32'(err), 32'(err6));
    step();
    ea = a + 6'd4;
    check("valid_idle", 32'(valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("re_n_idle", 32'(re_n), 32'd1);
    check("ptr_after", 32'(r_addr), 32'(ea));
    check("op1_held", 32'(OP1), 32'(e1));
  endtask

  initial begin
`ifdef MATRIX_RD_ZCHK_EN
    zchk = 1'b1;
`else
    zchk = 1'b0;
`endif
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = 32'h0000_0011;
    mem[1]  = 32'h0000_0022;
    mem[2]  = 32'h0000_0033;
    mem[3]  = 32'h0003_FFFF;
    mem[4]  = 32'h0000_0044;
    mem[5]  = 32'h0004_0005;
    mem[6]  = 32'h0000_0066;
    mem[7]  = 32'h0001_2345;
    mem[62] = 32'h0002_AAAA;
    mem[63] = 32'h0001_5555;
    dataRAM = 32'd0;
    rst     = 1'b1;
    start   = 1'b0;
    addr_ld = 1'b0;
    addr_in = 6'd0;

    step();
    step();
    check("rst_re_n", 32'(re_n), 32'd1);
    check("rst_r_addr", 32'(r_addr), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_op1", 32'(OP1), 32'd0);
    check("rst_op4", 32'(OP4), 32'd0);
    rst = 1'b0;

    burst(1'b0, 6'd0, 6'd0, 18'h00011, 18'h00022, 18'h00033, 18'h3FFFF,
          18'h00000, 1'b0, 1'b0, 1'b0);
    // Back-to-back from cycle 7, with an ignored start/addr_ld in cycle 3; word 5 has upper bits set.
    burst(1'b0, 6'd0, 6'd4, 18'h00044, 18'h00005, 18'h00066, 18'h12345,
          18'h3FFFF, 1'b0, zchk, 1'b1);
    // Load and start together, wrapping 62, 63, 0, 1.
    burst(1'b1, 6'd62, 6'd62, 18'h2AAAA, 18'h15555, 18'h00011, 18'h00022,
          18'h12345, zchk, zchk, 1'b0);

    // Reset abort in cycle 3 of a burst from pointer 2.
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_addr1", 32'(r_addr), 32'd2);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_re_n", 32'(re_n), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op1", 32'(OP1), 32'd0);
    check("abort_op2", 32'(OP2), 32'd0);
    check("abort_op3", 32'(OP3), 32'd0);
    check("abort_op4", 32'(OP4), 32'd0);
    check("abort_ptr", 32'(r_addr), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_valid", 32'(valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
